id_ex_hazard_ctrl: RTL and testbench

Hazard and pipeline-control block that drives the `Stall` and `flush` inputs of the ID/EX pipeline register and the matching IF/ID controls. It watches the EX-stage outputs of ID/EX and the decode-stage source registers. From these it generates:
- load-use bubbles;
- branch/jump redirect flushes;
- multi-cycle freezes for integer divide and FP divide/sqrt.

It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/mc_latency_counter.sv | 65 ++++++
 rtl/id_ex_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID/EX hazard controller.
//   state_e       : multi-cycle sequencer state (IDLE / BUSY)
//   HZ_CNT_W      : width of the multi-cycle down-counter
//   DIV_LAT_DEF   : default integer DIV/REM EX-stage latency
//   FDIV_LAT_DEF  : default FDIV/FSQRT EX-stage latency
//   lat_preload() : counter preload for a given total latency (LAT-2)
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int HZ_CNT_W     = 6;
  localparam int DIV_LAT_DEF  = 34;
  localparam int FDIV_LAT_DEF = 20;

  // The start cycle and the release cycle are not counted by cnt,
  // so a LAT-cycle operation preloads LAT-2.
  function automatic logic [HZ_CNT_W-1:0] lat_preload(input int lat);
    return HZ_CNT_W'(lat - 2);
  endfunction

endpackage

// File: rtl/mc_latency_counter.sv
// mc_latency_counter: holds the multi-cycle BUSY flag and the cnt down-counter.
// Ports:
//   clk        in  : clock
//   reset      in  : asynchronous active-low reset
//   load_i     in  : start request (honoured only in IDLE)
//   load_val_i in  : preload value for cnt
//   busy_o     out : sequencer is in BUSY
//   zero_o     out : cnt == 0
module mc_latency_counter
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [HZ_CNT_W-1:0] load_val_i,
  output logic                busy_o,
  output logic                zero_o
);

  state_e              state_q, state_d;
  logic [HZ_CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load on start, count down in BUSY, leave when cnt hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d = BUSY;
          cnt_d   = load_val_i;
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - {{(HZ_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == BUSY);
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl: load-use bubbles, redirect flushes and multi-cycle
// freezes for the ID/EX stage, plus a saturating stall-cycle counter.
// Optional feature: define HAZARD_FP_EN to enable the FP load-use term and
// FDIV/FSQRT freezes; otherwise the FP ports and FDIV_LAT are ignored.
// Ports:
//   Rs1D/Rs2D/Rs3D, UseRs1D/UseRs2D, UseFs1D/2D/3D : decode-stage sources
//   RdE, MemReadE, RegWriteE, RegFWriteE            : EX-stage producer info
//   DivE, FDivE                                     : multi-cycle op in EX
//   PCSrcE                                          : redirect resolved in EX
//   StallF/StallD/StallE, FlushD/FlushE             : pipeline controls (comb)
//   mc_busy, mc_done                                : multi-cycle status (comb)
//   stall_cycles                                    : saturating StallF count
module id_ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int FDIV_LAT = FDIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs3D,
  input  logic        UseRs1D,
  input  logic        UseRs2D,
  input  logic        UseFs1D,
  input  logic        UseFs2D,
  input  logic        UseFs3D,
  input  logic [4:0]  RdE,
  input  logic        MemReadE,
  input  logic        RegWriteE,
  input  logic        RegFWriteE,
  input  logic        DivE,
  input  logic        FDivE,
  input  logic        PCSrcE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        mc_busy,
  output logic        mc_done,
  output logic [31:0] stall_cycles
);

  localparam logic [HZ_CNT_W-1:0] DIV_PRE  = lat_preload(DIV_LAT);
  localparam logic [HZ_CNT_W-1:0] FDIV_PRE = lat_preload(FDIV_LAT);

  logic                hazard_int_s;
  logic                hazard_fp_s;
  logic                hazard_s;
  logic                mc_start_s;
  logic [HZ_CNT_W-1:0] load_val_s;
  logic                busy_s;
  logic                zero_s;
  logic [31:0]         stall_cycles_q, stall_cycles_d;

  assign hazard_int_s = MemReadE & RegWriteE & (RdE != 5'd0) &
                        ((UseRs1D & (RdE == Rs1D)) | (UseRs2D & (RdE == Rs2D)));

`ifdef HAZARD_FP_EN
  // f0 is a real FP register, so no RdE != 0 qualifier here.
  assign hazard_fp_s = MemReadE & RegFWriteE &
                       ((UseFs1D & (RdE == Rs1D)) | (UseFs2D & (RdE == Rs2D)) |
                        (UseFs3D & (RdE == Rs3D)));
  assign mc_start_s  = DivE | FDivE;
`else
  logic unused_fp_s;
  assign unused_fp_s = ^{UseFs1D, UseFs2D, UseFs3D, Rs3D, RegFWriteE, FDivE, FDIV_PRE};
  assign hazard_fp_s = 1'b0;
  assign mc_start_s  = DivE;
`endif

  assign hazard_s = hazard_int_s | hazard_fp_s;

  // DivE wins when both multi-cycle requests arrive together.
  assign load_val_s = DivE ? DIV_PRE : FDIV_PRE;

  mc_latency_counter u_mc_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (mc_start_s),
    .load_val_i (load_val_s),
    .busy_o     (busy_s),
    .zero_o     (zero_s)
  );

  // Pipeline controls: reset > multi-cycle freeze > redirect > load-use.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    if (!reset) begin
      mc_busy = 1'b0;
    end else if (busy_s) begin
      mc_busy = 1'b1;
      if (!zero_s) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
      end else begin
        mc_done = 1'b1;
      end
    end else if (mc_start_s) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      mc_busy = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (hazard_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      mc_busy = 1'b0;
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (StallF && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
module tb_id_ex_hazard_ctrl;

`ifdef HAZARD_FP_EN
  localparam logic FP_EN = 1'b1;
`else
  localparam logic FP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs3D, RdE;
  logic        UseRs1D, UseRs2D, UseFs1D, UseFs2D, UseFs3D;
  logic        MemReadE, RegWriteE, RegFWriteE, DivE, FDivE, PCSrcE;
  logic        StallF, StallD, StallE, FlushD, FlushE, mc_busy, mc_done;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int exp_sc   = 0;
  int stall_cnt;
  logic got_done;

  id_ex_hazard_ctrl #(.DIV_LAT(34), .FDIV_LAT(20)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs3D(Rs3D),
    .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .UseFs1D(UseFs1D), .UseFs2D(UseFs2D), .UseFs3D(UseFs3D),
    .RdE(RdE), .MemReadE(MemReadE), .RegWriteE(RegWriteE), .RegFWriteE(RegFWriteE),
    .DivE(DivE), .FDivE(FDivE), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs3D = 5'd0; RdE = 5'd0;
    UseRs1D = 1'b0; UseRs2D = 1'b0; UseFs1D = 1'b0; UseFs2D = 1'b0; UseFs3D = 1'b0;
    MemReadE = 1'b0; RegWriteE = 1'b0; RegFWriteE = 1'b0;
    DivE = 1'b0; FDivE = 1'b0; PCSrcE = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    DivE  = 1'b1;
    // Reset forces all controls low even with a divide request present.
    @(negedge clk); #1;
    check("rst_stallf", StallF, 0);
    check("rst_stalle", StallE, 0);
    check("rst_busy", mc_busy, 0);
    check("rst_flushe", FlushE, 0);
    check("rst_sc", stall_cycles, 0);
    idle_inputs();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    check("idle_stallf", StallF, 0);

    // Integer load-use on rs1
    @(negedge clk);
    MemReadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; UseRs1D = 1'b1;
    #1;
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushe", FlushE, 1);
    check("lu_stalle", StallE, 0);
    check("lu_flushd", FlushD, 0);
    exp_sc = 1;
    @(negedge clk); idle_inputs(); #1;
    check("lu_bubble_stallf", StallF, 0);
    check("lu_sc", stall_cycles, exp_sc);

    // RdE = x0 never raises a hazard
    @(negedge clk);
    MemReadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; UseRs1D = 1'b1;
    #1;
    check("lu_x0_stallf", StallF, 0);

    // Load-use on rs2 only
    @(negedge clk); idle_inputs();
    MemReadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; UseRs2D = 1'b1;
    Rs1D = 5'd3; UseRs1D = 1'b1;
    #1;
    check("lu_rs2_stalld", StallD, 1);
    exp_sc = 2;
    // Not a load: no hazard
    @(negedge clk); MemReadE = 1'b0; #1;
    check("nolu_stallf", StallF, 0);

    // Divide freeze: 33 stalled cycles, release in cycle 34
    @(negedge clk); idle_inputs(); DivE = 1'b1; #1;
    check("div_c1_stalle", StallE, 1);
    check("div_c1_stallf", StallF, 1);
    check("div_c1_busy", mc_busy, 1);
    check("div_c1_done", mc_done, 0);
    for (int k = 2; k <= 34; k++) begin
      @(negedge clk); idle_inputs(); #1;
      check("div_stalle", StallE, (k <= 33) ? 1 : 0);
      check("div_done", mc_done, (k == 34) ? 1 : 0);
    end
    check("div_c34_busy", mc_busy, 1);
    @(negedge clk); #1;
    check("div_after_busy", mc_busy, 0);
    exp_sc = exp_sc + 33;
    check("div_sc", stall_cycles, exp_sc);

    // Redirect overrides load-use
    @(negedge clk);
    MemReadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd9; Rs1D = 5'd9; UseRs1D = 1'b1; PCSrcE = 1'b1;
    #1;
    check("rd_flushd", FlushD, 1);
    check("rd_flushe", FlushE, 1);
    check("rd_stallf", StallF, 0);
    check("rd_stalld", StallD, 0);

    // Redirect ignored while BUSY
    @(negedge clk); idle_inputs(); DivE = 1'b1; #1;
    @(negedge clk); idle_inputs(); PCSrcE = 1'b1; #1;
    check("busy_rd_flushd", FlushD, 0);
    check("busy_rd_flushe", FlushE, 0);
    check("busy_rd_stallf", StallF, 1);
    @(negedge clk); idle_inputs();
    got_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (mc_done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("busy_done_seen", got_done, 1);
    exp_sc = exp_sc + 33;
    @(negedge clk); #1;
    check("busy_sc", stall_cycles, exp_sc);

    // FP load-use on rs3/f0
    @(negedge clk);
    MemReadE = 1'b1; RegFWriteE = 1'b1; RdE = 5'd0; Rs3D = 5'd0; UseFs3D = 1'b1;
    #1;
    check("fplu_stallf", StallF, FP_EN);
    check("fplu_flushe", FlushE, FP_EN);
    check("fplu_stalle", StallE, 0);
    exp_sc = exp_sc + (FP_EN ? 1 : 0);
    @(negedge clk); idle_inputs(); #1;
    check("fplu_sc", stall_cycles, exp_sc);

    // Reset in cycle 10 of a divide, then an FP divide
    @(negedge clk); DivE = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk); idle_inputs();
    end
    @(negedge clk); reset = 1'b0; #1;
    check("mrst_stallf", StallF, 0);
    check("mrst_stalle", StallE, 0);
    check("mrst_busy", mc_busy, 0);
    check("mrst_sc", stall_cycles, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); FDivE = 1'b1; #1;
    check("fdiv_c1_stalle", StallE, FP_EN);
    stall_cnt = (StallE === 1'b1) ? 1 : 0;
    for (int k = 2; k <= 25; k++) begin
      @(negedge clk); idle_inputs(); #1;
      if (StallE === 1'b1) stall_cnt++;
    end
    check("fdiv_stall_count", stall_cnt, FP_EN ? 19 : 0);
    check("fdiv_sc", stall_cycles, FP_EN ? 19 : 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
